// File: rtl/multicycle_datapath.sv
// Multi-cycle 16-bit-instruction datapath: FETCH/DECODE/EXECUTE/WRITEBACK sequencer
// with PC, IR, 16-entry register file, immediate extension, ALU and registered PSR.
module multicycle_datapath #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ready,
  input  logic [15:0]           mem_rdata,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [15:0]           psr,
  output logic [1:0]            state,
  input  logic [3:0]            dbg_reg_addr,
  output logic [DATA_WIDTH-1:0] dbg_reg_data
);

  localparam logic [1:0] S_FETCH  = 2'b00;
  localparam logic [1:0] S_DECODE = 2'b01;
  localparam logic [1:0] S_EXEC   = 2'b10;
  localparam logic [1:0] S_WB     = 2'b11;

  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_MOV = 4'hD;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 2;
  localparam int unsigned FLAG_F = 5;
  localparam int unsigned FLAG_Z = 6;
  localparam int unsigned FLAG_N = 7;
  localparam int unsigned MSB    = DATA_WIDTH - 1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           ir_q, ir_d;
  logic [15:0]           psr_q, psr_d;
  logic [15:0]           psr_nxt_q, psr_nxt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic                  mem_req_q, mem_req_d;
  logic [DATA_WIDTH-1:0] rf_q [16];
  logic                  rf_we;

  logic [3:0]            opcode, rdest, rsrc, code;
  logic                  is_rr, op_valid, sext, wr_en;
  logic [DATA_WIDTH-1:0] imm_ext;

  // Register-register ops carry their code in opext; immediate ops in the opcode.
  always_comb begin : decode
    opcode   = ir_q[15:12];
    rdest    = ir_q[11:8];
    rsrc     = ir_q[3:0];
    is_rr    = (opcode == 4'h0);
    code     = is_rr ? ir_q[7:4] : opcode;
    op_valid = 1'b0;
    sext     = 1'b0;
    case (code)
      OP_ADD, OP_SUB, OP_CMP, OP_MOV: begin
        op_valid = 1'b1;
        sext     = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR: op_valid = 1'b1;
      default: ;
    endcase
    wr_en   = op_valid && (code != OP_CMP);
    imm_ext = sext ? {{(DATA_WIDTH-8){ir_q[7]}}, ir_q[7:0]} : DATA_WIDTH'(ir_q[7:0]);
  end

  logic [DATA_WIDTH:0]   sum_ext;
  logic [DATA_WIDTH-1:0] diff, alu_res;
  logic [15:0]           flags;

  // ALU result and next PSR; undefined codes leave the PSR untouched.
  always_comb begin : alu
    sum_ext = {1'b0, a_q} + {1'b0, b_q};
    diff    = a_q - b_q;
    alu_res = a_q;
    flags   = psr_q;
    case (code)
      OP_ADD: begin
        alu_res        = sum_ext[MSB:0];
        flags[FLAG_C]  = sum_ext[DATA_WIDTH];
        flags[FLAG_F]  = (a_q[MSB] == b_q[MSB]) && (sum_ext[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_res        = diff;
        flags[FLAG_C]  = (a_q < b_q);
        flags[FLAG_F]  = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_MOV: alu_res = b_q;
      OP_CMP: begin
        flags[FLAG_Z] = (a_q == b_q);
        flags[FLAG_L] = (a_q < b_q);
        flags[FLAG_N] = ($signed(a_q) < $signed(b_q));
      end
      default: ;
    endcase
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    psr_d     = psr_q;
    psr_nxt_d = psr_nxt_q;
    rf_we     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_req_q && mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[rdest];
        b_d     = is_rr ? rf_q[rsrc] : imm_ext;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d     = alu_res;
        psr_nxt_d = flags;
        state_d   = S_WB;
      end
      default: begin
        rf_we   = wr_en;
        psr_d   = psr_nxt_q;
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = S_FETCH;
      end
    endcase
    mem_req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      psr_q     <= '0;
      psr_nxt_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      mem_req_q <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      psr_q     <= psr_d;
      psr_nxt_q <= psr_nxt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      mem_req_q <= mem_req_d;
      if (rf_we) rf_q[rdest] <= res_q;
    end
  end

  assign mem_addr     = pc_q;
  assign mem_req      = mem_req_q;
  assign pc           = pc_q;
  assign psr          = psr_q;
  assign state        = state_q;
  assign dbg_reg_data = rf_q[dbg_reg_addr];

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: a 16-bit instance and a 32-bit
// instance with RESET_PC=0xFFFF, checked on every instruction retirement.
module tb_multicycle_datapath;

  typedef struct {
    string       nm;
    logic [3:0]  ra;
    logic [31:0] rv;
    logic [15:0] psr;
    logic [15:0] pc;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16_n, rst32_n, rdy16, rdy32;
  logic [15:0] rd16, rd32;
  logic [15:0] addr16, pc16, psr16, addr32, pc32, psr32;
  logic        mreq16, mreq32;
  logic [1:0]  st16, st32;
  logic [3:0]  dbg_a16, dbg_a32, probe_a;
  logic [3:0]  mon_a16 = 4'h0;
  logic [3:0]  mon_a32 = 4'h0;
  logic        probe16, probe32;
  logic [15:0] dbg_d16;
  logic [31:0] dbg_d32;

  assign dbg_a16 = probe16 ? probe_a : mon_a16;
  assign dbg_a32 = probe32 ? probe_a : mon_a32;

  int   nchk = 0;
  int   nfail = 0;
  int   cyc = 0;
  exp_t q16[$];
  exp_t q32[$];

  always @(posedge clk) cyc <= cyc + 1;

  multicycle_datapath u_dp16 (
    .clock(clk), .reset(rst16_n), .mem_addr(addr16), .mem_req(mreq16),
    .mem_ready(rdy16), .mem_rdata(rd16), .pc(pc16), .psr(psr16), .state(st16),
    .dbg_reg_addr(dbg_a16), .dbg_reg_data(dbg_d16)
  );

  multicycle_datapath #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .RESET_PC(16'hFFFF)) u_dp32 (
    .clock(clk), .reset(rst32_n), .mem_addr(addr32), .mem_req(mreq32),
    .mem_ready(rdy32), .mem_rdata(rd32), .pc(pc32), .psr(psr32), .state(st32),
    .dbg_reg_addr(dbg_a32), .dbg_reg_data(dbg_d32)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    nchk++;
    nfail++;
    $display("FAIL %s: retirement with empty scoreboard, got 1 expected 0", nm);
  endtask

  // Retirement monitors: a WRITEBACK->FETCH transition marks a completed instruction.
  logic [1:0] prev16 = 2'b00;
  always @(negedge clk) begin : mon16
    exp_t e;
    if (prev16 == 2'b11 && st16 == 2'b00) begin
      if (q16.size() == 0) unexpected("retire16");
      else begin
        e = q16.pop_front();
        mon_a16 = e.ra;
        #1;
        check({e.nm, "_reg"}, 32'(dbg_d16), e.rv);
        check({e.nm, "_psr"}, 32'(psr16), 32'(e.psr));
        check({e.nm, "_pc"}, 32'(pc16), 32'(e.pc));
        check({e.nm, "_lat"}, 32'(cyc - e.acc), 32'd3);
      end
    end
    prev16 = st16;
  end

  logic [1:0] prev32 = 2'b00;
  always @(negedge clk) begin : mon32
    exp_t e;
    if (prev32 == 2'b11 && st32 == 2'b00) begin
      if (q32.size() == 0) unexpected("retire32");
      else begin
        e = q32.pop_front();
        mon_a32 = e.ra;
        #1;
        check({e.nm, "_reg"}, dbg_d32, e.rv);
        check({e.nm, "_psr"}, 32'(psr32), 32'(e.psr));
        check({e.nm, "_pc"}, 32'(pc32), 32'(e.pc));
        check({e.nm, "_lat"}, 32'(cyc - e.acc), 32'd3);
      end
    end
    prev32 = st32;
  end

  // Serve one instruction once the DUT requests it, after 'waits' stall cycles.
  task automatic issue(input bit sel, input logic [15:0] instr, input int waits, input bit push,
                       input string nm, input logic [3:0] ra, input logic [31:0] rv,
                       input logic [15:0] epsr, input logic [15:0] epc);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!(sel ? (mreq32 && st32 == 2'b00) : (mreq16 && st16 == 2'b00)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check({nm, "_fetch_timeout"}, 32'd1, 32'd0);
      return;
    end
    repeat (waits) @(negedge clk);
    check({nm, "_addr"}, 32'(sel ? addr32 : addr16), 32'(16'(epc - 16'd1)));
    if (sel) begin rd32 = instr; rdy32 = 1'b1; end
    else     begin rd16 = instr; rdy16 = 1'b1; end
    if (push) begin
      e.nm = nm; e.ra = ra; e.rv = rv; e.psr = epsr; e.pc = epc; e.acc = cyc + 1;
      if (sel) q32.push_back(e);
      else     q16.push_back(e);
    end
    @(negedge clk);
    rdy16 = 1'b0;
    rdy32 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst16_n = 1'b0; rst32_n = 1'b0; rdy16 = 1'b0; rdy32 = 1'b0;
    rd16 = 16'h0; rd32 = 16'h0; probe16 = 1'b1; probe32 = 1'b1; probe_a = 4'd3;

    // Reset held, then released with memory stalled.
    repeat (3) begin
      @(negedge clk);
      check("rst_mreq", 32'(mreq16), 32'd0);
      check("rst_pc", 32'(pc16), 32'd0);
      check("rst_state", 32'(st16), 32'd0);
      check("rst_psr", 32'(psr16), 32'd0);
      check("rst_dbg", 32'(dbg_d16), 32'd0);
    end
    check("rst32_pc", 32'(pc32), 32'h0000FFFF);
    check("rst32_mreq", 32'(mreq32), 32'd0);
    probe16 = 1'b0;
    probe32 = 1'b0;
    rst16_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("wait_mreq", 32'(mreq16), 32'd1);
      check("wait_addr", 32'(addr16), 32'd0);
      check("wait_state", 32'(st16), 32'd0);
      check("wait_pc", 32'(pc16), 32'd0);
    end

    issue(0, 16'hD1FF, 0, 1, "movi_r1", 4'd1, 32'h0000FFFF, 16'h0000, 16'd1);
    issue(0, 16'h22FF, 0, 1, "ori_r2",  4'd2, 32'h000000FF, 16'h0000, 16'd2);
    issue(0, 16'hD37F, 0, 1, "movi_r3", 4'd3, 32'h0000007F, 16'h0000, 16'd3);
    for (int k = 1; k <= 8; k++)
      issue(0, 16'h0353, 0, 1, "add_dbl", 4'd3, 32'(16'h007F << k), 16'h0000, 16'(3 + k));
    issue(0, 16'h23FF, 0, 1, "ori_r3",  4'd3, 32'h00007FFF, 16'h0000, 16'd12);
    issue(0, 16'h5301, 0, 1, "addi_ovf", 4'd3, 32'h00008000, 16'h0020, 16'd13);
    issue(0, 16'h9301, 0, 1, "subi_ovf", 4'd3, 32'h00007FFF, 16'h0020, 16'd14);
    issue(0, 16'h5301, 1, 1, "addi_again", 4'd3, 32'h00008000, 16'h0020, 16'd15);
    issue(0, 16'h0353, 0, 1, "add_carry", 4'd3, 32'h00000000, 16'h0021, 16'd16);
    issue(0, 16'hD405, 2, 1, "movi_r4", 4'd4, 32'h00000005, 16'h0021, 16'd17);
    issue(0, 16'hD5FF, 0, 1, "movi_r5", 4'd5, 32'h0000FFFF, 16'h0021, 16'd18);
    issue(0, 16'h04B5, 1, 1, "cmp_lt",  4'd4, 32'h00000005, 16'h0025, 16'd19);
    issue(0, 16'h04B4, 0, 1, "cmp_eq",  4'd4, 32'h00000005, 16'h0061, 16'd20);
    issue(0, 16'hB500, 0, 1, "cmpi_neg", 4'd5, 32'h0000FFFF, 16'h00A1, 16'd21);
    issue(0, 16'h0291, 0, 1, "sub_rr",  4'd2, 32'h00000100, 16'h0081, 16'd22);
    issue(0, 16'h9301, 0, 1, "subi_brw", 4'd3, 32'h0000FFFF, 16'h0081, 16'd23);
    issue(0, 16'h110F, 0, 1, "andi_zx", 4'd1, 32'h0000000F, 16'h0081, 16'd24);
    issue(0, 16'h0132, 0, 1, "xor_rr",  4'd1, 32'h0000010F, 16'h0081, 16'd25);
    issue(0, 16'h32FF, 0, 1, "xori_zx", 4'd2, 32'h000001FF, 16'h0081, 16'd26);
    issue(0, 16'h06D1, 0, 1, "mov_rr",  4'd6, 32'h0000010F, 16'h0081, 16'd27);
    issue(0, 16'hF123, 0, 1, "nop_op",  4'd1, 32'h0000010F, 16'h0081, 16'd28);
    issue(0, 16'h0172, 0, 1, "nop_ext", 4'd1, 32'h0000010F, 16'h0081, 16'd29);
    issue(0, 16'hD012, 0, 1, "movi_r0", 4'd0, 32'h00000012, 16'h0081, 16'd30);
    issue(0, 16'h50FE, 0, 1, "addi_neg", 4'd0, 32'h00000010, 16'h0081, 16'd31);

    // Abandon ADDI r6,#3 by resetting during its EXECUTE cycle.
    issue(0, 16'h5603, 0, 0, "addi_abort", 4'd6, 32'h0, 16'h0, 16'd32);
    n = 0;
    while (st16 != 2'b10 && n < 10) begin @(negedge clk); n++; end
    check("abort_reach_exec", 32'(st16), 32'd2);
    rst16_n = 1'b0;
    probe16 = 1'b1;
    probe_a = 4'd6;
    #1;
    check("abort_r6", 32'(dbg_d16), 32'd0);
    check("abort_psr", 32'(psr16), 32'd0);
    check("abort_pc", 32'(pc16), 32'd0);
    check("abort_state", 32'(st16), 32'd0);
    check("abort_mreq", 32'(mreq16), 32'd0);
    probe_a = 4'd1;
    #1;
    check("abort_r1", 32'(dbg_d16), 32'd0);
    probe16 = 1'b0;
    repeat (2) @(negedge clk);
    rst16_n = 1'b1;
    issue(0, 16'h5603, 0, 1, "addi_after_rst", 4'd6, 32'h00000003, 16'h0000, 16'd1);

    // 32-bit instance: PC wrap and wide sign extension.
    @(negedge clk);
    rst32_n = 1'b1;
    issue(1, 16'hF000, 0, 1, "nop_wrap",  4'd7, 32'h00000000, 16'h0000, 16'h0000);
    issue(1, 16'h9701, 0, 1, "subi32",    4'd7, 32'hFFFFFFFF, 16'h0001, 16'h0001);
    issue(1, 16'h5701, 0, 1, "addi32",    4'd7, 32'h00000000, 16'h0001, 16'h0002);
    issue(1, 16'hD880, 0, 1, "movi32",    4'd8, 32'hFFFFFF80, 16'h0001, 16'h0003);
    issue(1, 16'h18F0, 0, 1, "andi32",    4'd8, 32'h00000080, 16'h0001, 16'h0004);
    issue(1, 16'hB8FF, 0, 1, "cmpi32",    4'd8, 32'h00000080, 16'h0005, 16'h0005);

    repeat (8) @(negedge clk);
    check("q16_drained", 32'(q16.size()), 32'd0);
    check("q32_drained", 32'(q32.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
